// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory responder: RV32I width codes,
// FSM state encoding and the alignment/funct3 legality check.
package data_memory_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    // Range checking lives in the top because it depends on DEPTH_WORDS.
    function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad;
        if (wr) bad = (f3 > SW);
        else    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        case (f3[1:0])
            2'd1:    if (off[0]) bad = 1'b1;
            2'd2:    if (off != 2'd0) bad = 1'b1;
            default: ;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-organised storage with per-byte write enables and a registered read
// port. Contents are deliberately never reset.
module data_memory_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// CPU data-memory responder: one request at a time, fixed wait states, then a
// held response until the CPU takes it. Lane steering and load extension here.
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    input  logic [2:0]  reqFunct3,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respReadData,
    output logic        respError
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, err_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;

    logic        accept, enter_resp;
    logic        cur_write, cur_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;
    logic [3:0]  be;
    logic [31:0] lane_wdata, rdata, shifted, ext;

    assign reqReady = (state_q == ST_IDLE);
    assign accept   = reqValid && reqReady;

    // With zero wait states RESPOND is entered on the accept edge itself,
    // so the live request fields have to feed the array directly.
    assign cur_write = reqReady ? reqWrite     : write_q;
    assign cur_addr  = reqReady ? reqAddress   : addr_q;
    assign cur_wdata = reqReady ? reqWriteData : wdata_q;
    assign cur_f3    = reqReady ? reqFunct3    : f3_q;
    assign cur_err   = access_err(cur_write, cur_f3, cur_addr[1:0]) ||
                       ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESPOND;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESPOND;
                    enter_resp = 1'b1;
                end
            end
            ST_RESPOND: if (respReady) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= reqWrite;
                addr_q  <= reqAddress;
                wdata_q <= reqWriteData;
                f3_q    <= reqFunct3;
            end
            if (enter_resp) err_q <= cur_err;
        end
    end

    always_comb begin
        be         = 4'b0000;
        lane_wdata = cur_wdata;
        case (cur_f3)
            SB: begin
                be         = 4'b0001 << cur_addr[1:0];
                lane_wdata = {4{cur_wdata[7:0]}};
            end
            SH: begin
                be         = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cur_wdata[15:0]}};
            end
            SW:      be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // resetN gate keeps a store sampled during reset from reaching the array.
    data_memory_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clk     (clk),
        .we_i    (enter_resp && cur_write && !cur_err && resetN),
        .be_i    (be),
        .re_i    (enter_resp && !cur_write && !cur_err),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (lane_wdata),
        .rdata_o (rdata)
    );

    assign shifted = rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ext = 32'd0;
        case (f3_q)
            LB:      ext = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     ext = {24'd0, shifted[7:0]};
            LH:      ext = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     ext = {16'd0, shifted[15:0]};
            LW:      ext = rdata;
            default: ext = 32'd0;
        endcase
    end

    assign respValid    = (state_q == ST_RESPOND);
    assign respError    = respValid && err_q;
    assign respReadData = (respValid && !err_q && !write_q) ? ext : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a default build (2 wait states) and a
// zero-wait build, checked against a byte-array reference model.
module tb_data_memory_responder;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    logic        vld [2];
    logic        wr  [2];
    logic        rrdy[2];
    logic [31:0] addr[2];
    logic [31:0] wdat[2];
    logic [2:0]  f3  [2];

    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    logic        o_rdy[2], o_rv[2], o_er[2];
    logic [31:0] o_rd [2];

    always_comb begin
        o_rdy[0] = rdy0; o_rdy[1] = rdy1;
        o_rv[0]  = rv0;  o_rv[1]  = rv1;
        o_er[0]  = er0;  o_er[1]  = er1;
        o_rd[0]  = rd0;  o_rd[1]  = rd1;
    end

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .resetN(resetN),
        .reqValid(vld[0]), .reqReady(rdy0), .reqWrite(wr[0]),
        .reqAddress(addr[0]), .reqWriteData(wdat[0]), .reqFunct3(f3[0]),
        .respValid(rv0), .respReady(rrdy[0]), .respReadData(rd0), .respError(er0)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .resetN(resetN),
        .reqValid(vld[1]), .reqReady(rdy1), .reqWrite(wr[1]),
        .reqAddress(addr[1]), .reqWriteData(wdat[1]), .reqFunct3(f3[1]),
        .respValid(rv1), .respReady(rrdy[1]), .respReadData(rd1), .respError(er1)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] mem_m [2][128];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, plain arithmetic.
    task automatic model(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f,
                         output logic e, output logic [31:0] r);
        int n;
        logic [31:0] v;
        n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        e = 1'b0;
        r = 32'd0;
        if (w && f > 3'd2) e = 1'b1;
        if (!w && (f == 3'd3 || f >= 3'd6)) e = 1'b1;
        if (a % n != 0) e = 1'b1;
        if (a / 4 >= 256) e = 1'b1;
        if (e) return;
        if (w) begin
            for (int i = 0; i < n; i++) mem_m[d][a + i] = 8'(wd >> (8 * i));
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[d][a + i]) << (8 * i));
            if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            r = v;
        end
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f, input int hold);
        logic        e_m, e0;
        logic [31:0] r_m, r0;
        int          lat;
        model(d, w, a, wd, f, e_m, r_m);
        @(negedge clk);
        chk("req_ready_idle", o_rdy[d], 1'b1);
        vld[d] = 1'b1; wr[d] = w; addr[d] = a; wdat[d] = wd; f3[d] = f;
        @(negedge clk);
        vld[d] = 1'b0;
        lat = 1;
        while (!o_rv[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_latency", lat, (d == 0) ? 3 : 1);
        chk("resp_error", o_er[d], e_m);
        chk("resp_data", o_rd[d], r_m);
        r0 = o_rd[d];
        e0 = o_er[d];
        for (int i = 0; i < hold; i++) begin
            vld[d] = 1'b1; wr[d] = 1'b1; addr[d] = 32'h10; wdat[d] = $urandom; f3[d] = 3'd2;
            @(negedge clk);
            chk("hold_valid", o_rv[d], 1'b1);
            chk("hold_data", o_rd[d], r0);
            chk("hold_err", o_er[d], e0);
            chk("hold_ready", o_rdy[d], 1'b0);
        end
        vld[d]  = 1'b0;
        rrdy[d] = 1'b1;
        @(negedge clk);
        rrdy[d] = 1'b0;
        chk("post_valid", o_rv[d], 1'b0);
        chk("post_ready", o_rdy[d], 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int          word;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 0; wr[d] = 0; rrdy[d] = 0; addr[d] = 0; wdat[d] = 0; f3[d] = 0;
        end
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", o_rdy[d], 1'b1);
            chk("rst_valid", o_rv[d], 1'b0);
            chk("rst_data", o_rd[d], 32'd0);
            chk("rst_err", o_er[d], 1'b0);
        end
        resetN = 1'b1;

        // Give every modelled word a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) txn(d, 1'b1, 32'(i * 4), $urandom, 3'd2, 0);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'd2, 0);
        txn(0, 1'b1, 32'h11, 32'h0000_0080, 3'd0, 0);
        txn(0, 1'b0, 32'h11, 32'h0, 3'd0, 0);
        txn(0, 1'b0, 32'h11, 32'h0, 3'd4, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'd2, 0);
        txn(0, 1'b0, 32'h12, 32'h0, 3'd2, 0);
        txn(0, 1'b1, 32'h13, 32'h5555_AAAA, 3'd1, 0);
        txn(0, 1'b0, 32'h400, 32'h0, 3'd2, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'd2, 5);
        txn(0, 1'b0, 32'h10, 32'h0, 3'd2, 0);

        for (int i = 0; i < 4; i++) txn(1, 1'b0, 32'(i * 4), 32'h0, 3'd2, 0);

        // Abort a store while it waits; it must never commit.
        txn(0, 1'b1, 32'h20, 32'h0, 3'd2, 0);
        @(negedge clk);
        vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wdat[0] = 32'h12345678; f3[0] = 3'd2;
        @(negedge clk);
        vld[0] = 1'b0;
        resetN = 1'b0;
        @(negedge clk);
        chk("abort_rst_ready", o_rdy[0], 1'b1);
        chk("abort_rst_valid", o_rv[0], 1'b0);
        resetN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", o_rv[0], 1'b0);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 3'd2, 0);

        for (int i = 0; i < 300; i++) begin
            word = ($urandom_range(0, 9) == 0) ? 256 + $urandom_range(0, 100) : $urandom_range(0, 31);
            a    = 32'(word * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
            else                          f = 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'd4 : 3'd0);
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom, f, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
